// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned IFQ_XLEN = 32;
  localparam int unsigned IFQ_ILEN = 32;
  localparam logic [IFQ_XLEN-1:0] IFQ_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_ILEN-1:0] instr;
  } ifq_entry_t;

  function automatic logic [IFQ_XLEN-1:0] ifq_align(input logic [IFQ_XLEN-1:0] addr);
    return {addr[IFQ_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched {pc, instr} entries with synchronous flush.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  ifq_entry_t               push_data_i,
  input  logic                     pop_i,
  output ifq_entry_t               head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
    count_o = count_q;
    head_o  = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked by empty in the top.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction prefetcher: one outstanding memory read, results
// buffered in a small FIFO, redirect flushes and refetches from the target.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned          DEPTH    = 4,
  parameter logic [IFQ_XLEN-1:0]  RESET_PC = IFQ_RESET_PC
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                redirect_i,
  input  logic [IFQ_XLEN-1:0] redirect_pc_i,
  output logic                mem_req_o,
  output logic [IFQ_XLEN-1:0] mem_addr_o,
  input  logic                mem_ack_i,
  input  logic [IFQ_ILEN-1:0] mem_rdata_i,
  output logic                instr_valid_o,
  output logic [IFQ_ILEN-1:0] instr_o,
  output logic [IFQ_XLEN-1:0] instr_pc_o,
  input  logic                instr_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ifq_state_e          state_q, state_d;
  logic [IFQ_XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [IFQ_XLEN-1:0] drop_pc_q, drop_pc_d;
  logic                started_q, started_d;

  logic                ack;
  logic                push;
  logic                pop;
  logic                full_after_push;
  logic [IFQ_XLEN-1:0] target_pc;
  ifq_entry_t          push_data;
  ifq_entry_t          head;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CW-1:0]       fifo_count;

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // started_q keeps the request low for the first cycle out of reset.
  always_comb begin
    mem_req_o     = started_q && (state_q != S_HOLD);
    mem_addr_o    = fetch_pc_q;
    instr_valid_o = !fifo_empty;
    instr_o       = fifo_empty ? '0 : head.instr;
    instr_pc_o    = fifo_empty ? '0 : head.pc;
  end

  always_comb begin
    ack             = mem_ack_i && mem_req_o;
    pop             = instr_valid_o && instr_ready_i && !redirect_i;
    push            = ack && (state_q == S_REQ) && !redirect_i;
    push_data.pc    = fetch_pc_q;
    push_data.instr = mem_rdata_i;
    target_pc       = ifq_align(redirect_pc_i);
    full_after_push = !pop && (fifo_count == CW'(DEPTH - 1));
  end

  // In S_DROP the superseded address stays on mem_addr_o until its ack;
  // the redirect target waits in drop_pc_q.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_pc_d  = drop_pc_q;
    started_d  = 1'b1;
    unique case (state_q)
      S_REQ: begin
        if (redirect_i) begin
          if (ack || !started_q) begin
            fetch_pc_d = target_pc;
            state_d    = S_REQ;
          end else begin
            drop_pc_d = target_pc;
            state_d   = S_DROP;
          end
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = full_after_push ? S_HOLD : S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          fetch_pc_d = target_pc;
          state_d    = S_REQ;
        end else if (pop || !fifo_full) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          if (ack) begin
            fetch_pc_d = target_pc;
            state_d    = S_REQ;
          end else begin
            drop_pc_d = target_pc;
          end
        end else if (ack) begin
          fetch_pc_d = drop_pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      drop_pc_q  <= RESET_PC;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_pc_q  <= drop_pc_d;
      started_q  <= started_d;
    end
  end

endmodule
